// File: rtl/cyc_bus_handshake.sv
// cyc_bus_handshake: drives MREQ_n, IORQ_n or LSHADOW for one access and
// returns RT_n when the bus access or the shadow access completes.
// All strobes stay held until cycle control terminates the cycle with TERM_n.
// Ports:
//   sysclk, sys_rst   - clock, synchronous active-high reset
//   START, IO, SHADOW - one-cycle access start and access type (SHADOW overrides IO)
//   BUS_RDY           - bus-side ready, used only while requesting
//   TERM_n            - cycle termination from cycle control, honoured only in DONE
//   MREQ_n, IORQ_n    - memory / IO request strobes (active low)
//   LSHADOW           - shadow access in progress
//   RT_n              - ready/transfer complete (active low)
//   BUSY              - access in progress
//   TMO               - sticky timeout flag
module cyc_bus_handshake #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SHADOW_WAIT    = 2
) (
    input  logic sysclk,
    input  logic sys_rst,
    input  logic START,
    input  logic IO,
    input  logic SHADOW,
    input  logic BUS_RDY,
    input  logic TERM_n,
    output logic MREQ_n,
    output logic IORQ_n,
    output logic LSHADOW,
    output logic RT_n,
    output logic BUSY,
    output logic TMO
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SHD_LAST = CNT_W'(SHADOW_WAIT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_io_q;
    logic             r_shd_q;
    logic [CNT_W-1:0] r_cnt;

    logic             w_cnt_inc_en;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_complete;
    logic             w_timeout;

    // Saturating increment of the request-cycle counter
    assign w_cnt_inc_en = (r_cnt != CNT_MAX);
    assign w_cnt_inc    = w_cnt_inc_en ? (r_cnt + CNT_W'(1)) : r_cnt;

    // Shadow accesses complete on a fixed count; bus accesses on BUS_RDY
    assign w_complete = r_shd_q ? (r_cnt == SHD_LAST) : BUS_RDY;
    assign w_timeout  = (r_cnt == TMO_LAST);

    // Access sequencer with registered strobe/handshake outputs
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_io_q  <= 1'b0;
            r_shd_q <= 1'b0;
            r_cnt   <= '0;
            MREQ_n  <= 1'b1;
            IORQ_n  <= 1'b1;
            LSHADOW <= 1'b0;
            RT_n    <= 1'b1;
            BUSY    <= 1'b0;
            TMO     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= S_REQ;
                        r_io_q  <= IO;
                        r_shd_q <= SHADOW;
                        r_cnt   <= '0;
                        TMO     <= 1'b0;
                        MREQ_n  <= SHADOW | IO;
                        IORQ_n  <= SHADOW | ~IO;
                        LSHADOW <= SHADOW;
                        RT_n    <= 1'b1;
                        BUSY    <= 1'b1;
                    end
                end
                S_REQ, S_WAIT: begin
                    r_cnt   <= w_cnt_inc;
                    MREQ_n  <= r_shd_q | r_io_q;
                    IORQ_n  <= r_shd_q | ~r_io_q;
                    LSHADOW <= r_shd_q;
                    BUSY    <= 1'b1;
                    // Completion takes priority over a coincident timeout
                    if (w_complete) begin
                        r_state <= S_DONE;
                        RT_n    <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        RT_n    <= 1'b0;
                        TMO     <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    if (!TERM_n) begin
                        r_state <= S_IDLE;
                        MREQ_n  <= 1'b1;
                        IORQ_n  <= 1'b1;
                        LSHADOW <= 1'b0;
                        RT_n    <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
